// File: rtl/vcdl_delay_scan_ctrl.sv
// VCDL IDELAY calibration sweep: scans taps 0..31, finds the first 0->1 majority edge.
// Define VCDL_SCAN_HIST_EN to add a per-tap ones-count histogram readable via hist_addr_i.
module vcdl_delay_scan_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 16,
   parameter int unsigned NSAMPLES_LOG2 = 6,
   parameter int unsigned TAP_OFFSET    = 0
) (
   input  logic                     sysclk_i,
   input  logic                     rst_i,
   input  logic                     start_i,
   input  logic                     abort_i,
   input  logic                     fb_q_i,
   output logic [4:0]               delay_o,
   output logic                     load_o,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     found_o,
   output logic [4:0]               edge_tap_o,
   input  logic [4:0]               hist_addr_i,
   output logic [NSAMPLES_LOG2:0]   hist_data_o
);

   localparam int unsigned  CW          = NSAMPLES_LOG2 + 1;
   localparam logic [7:0]   SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [7:0]   SAMPLE_LAST = 8'((1 << NSAMPLES_LOG2) - 1);
   localparam logic [CW-1:0] HALF       = CW'(1 << (NSAMPLES_LOG2 - 1));
   localparam logic [5:0]   OFFSET      = 6'(TAP_OFFSET);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SETTLE, S_SAMPLE, S_EVAL, S_FINAL, S_ABORT, S_DONE
   } state_t;

   state_t        r_state, w_state_nxt;
   logic          r_fb_meta, r_fb_sync;
   logic [4:0]    r_tap, w_tap_nxt;
   logic [4:0]    r_delay, w_delay_nxt;
   logic [4:0]    r_restore, w_restore_nxt;
   logic [7:0]    r_cnt, w_cnt_nxt;
   logic [CW-1:0] r_ones, w_ones_nxt;
   logic          r_found, w_found_nxt;
   logic [4:0]    r_edge, w_edge_nxt;
   logic          r_prev_maj, w_prev_maj_nxt;
   logic          w_maj;
   logic          w_abort;
   logic          w_scan_start;
   logic [5:0]    w_final_sum;

   assign w_maj        = (r_ones > HALF);
   assign w_scan_start = (r_state == S_IDLE) && start_i && !abort_i;
   assign w_abort      = abort_i && ((r_state == S_LOAD) || (r_state == S_SETTLE) ||
                                     (r_state == S_SAMPLE) || (r_state == S_EVAL));

   always_comb begin
      w_state_nxt    = r_state;
      w_tap_nxt      = r_tap;
      w_delay_nxt    = r_delay;
      w_restore_nxt  = r_restore;
      w_cnt_nxt      = r_cnt;
      w_ones_nxt     = r_ones;
      w_found_nxt    = r_found;
      w_edge_nxt     = r_edge;
      w_prev_maj_nxt = r_prev_maj;
      w_final_sum    = '0;

      case (r_state)
         S_IDLE: begin
            if (w_scan_start) begin
               w_restore_nxt  = r_delay;
               w_found_nxt    = 1'b0;
               w_edge_nxt     = '0;
               w_prev_maj_nxt = 1'b0;
               w_tap_nxt      = '0;
               w_delay_nxt    = '0;
               w_state_nxt    = S_LOAD;
            end
         end
         S_LOAD: begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_SETTLE;
         end
         S_SETTLE: begin
            if (r_cnt == SETTLE_LAST) begin
               w_cnt_nxt   = '0;
               w_ones_nxt  = '0;
               w_state_nxt = S_SAMPLE;
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end
         S_SAMPLE: begin
            w_ones_nxt = r_ones + CW'(r_fb_sync);
            if (r_cnt == SAMPLE_LAST) begin
               w_state_nxt = S_EVAL;
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end
         S_EVAL: begin
            if (w_maj && !r_prev_maj && (r_tap != 5'd0) && !r_found) begin
               w_found_nxt = 1'b1;
               w_edge_nxt  = r_tap;
            end
            w_prev_maj_nxt = w_maj;
            if (r_tap == 5'd31) begin
               // final value uses this cycle's edge result so an edge at tap 31 is honoured
               w_final_sum = {1'b0, w_edge_nxt} + OFFSET;
               w_delay_nxt = w_found_nxt ? (w_final_sum[5] ? 5'd31 : w_final_sum[4:0]) : r_restore;
               w_state_nxt = S_FINAL;
            end else begin
               w_tap_nxt   = r_tap + 5'd1;
               w_delay_nxt = r_tap + 5'd1;
               w_state_nxt = S_LOAD;
            end
         end
         S_FINAL: w_state_nxt = S_DONE;
         S_ABORT: w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase

      if (w_abort) begin
         w_delay_nxt = r_restore;
         w_found_nxt = 1'b0;
         w_edge_nxt  = '0;
         w_state_nxt = S_ABORT;
      end
   end

   always_ff @(posedge sysclk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= S_IDLE;
         r_fb_meta  <= 1'b0;
         r_fb_sync  <= 1'b0;
         r_tap      <= '0;
         r_delay    <= '0;
         r_restore  <= '0;
         r_cnt      <= '0;
         r_ones     <= '0;
         r_found    <= 1'b0;
         r_edge     <= '0;
         r_prev_maj <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_fb_meta  <= fb_q_i;
         r_fb_sync  <= r_fb_meta;
         r_tap      <= w_tap_nxt;
         r_delay    <= w_delay_nxt;
         r_restore  <= w_restore_nxt;
         r_cnt      <= w_cnt_nxt;
         r_ones     <= w_ones_nxt;
         r_found    <= w_found_nxt;
         r_edge     <= w_edge_nxt;
         r_prev_maj <= w_prev_maj_nxt;
      end
   end

   assign delay_o    = r_delay;
   assign load_o     = (r_state == S_LOAD) || (r_state == S_FINAL) || (r_state == S_ABORT);
   assign busy_o     = (r_state != S_IDLE) && (r_state != S_DONE);
   assign done_o     = (r_state == S_DONE);
   assign found_o    = r_found;
   assign edge_tap_o = r_edge;

`ifdef VCDL_SCAN_HIST_EN
   logic [CW-1:0] r_hist [32];

   always_ff @(posedge sysclk_i or posedge rst_i) begin
      if (rst_i) begin
         r_hist <= '{default: '0};
      end else if (w_scan_start) begin
         for (int unsigned i = 0; i < 32; i++) r_hist[i] <= '0;
      end else if (r_state == S_EVAL) begin
         r_hist[r_tap] <= r_ones;
      end
   end

   assign hist_data_o = r_hist[hist_addr_i];
`else
   logic w_unused_hist;
   assign w_unused_hist = ^hist_addr_i;
   assign hist_data_o   = '0;
`endif

endmodule
